// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the frame drawing datapath: layer codes, screen size
// defaults, colour constants, sprite dimensions and the scan FSM state type.
// -----------------------------------------------------------------------------
package draw_pkg;

    localparam logic [1:0] LAYER_BG     = 2'd0;
    localparam logic [1:0] LAYER_SHIP   = 2'd1;
    localparam logic [1:0] LAYER_ENEMY  = 2'd2;
    localparam logic [1:0] LAYER_BULLET = 2'd3;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_YELLOW = 3'b110;

    localparam logic [7:0] SPRITE_W  = 8'd8;
    localparam logic [6:0] SPRITE_H  = 7'd8;
    localparam logic [7:0] BULLET_W  = 8'd1;
    localparam logic [6:0] BULLET_H  = 7'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic is_sprite(input logic [1:0] lay);
        return (lay == LAYER_SHIP) || (lay == LAYER_ENEMY);
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// -----------------------------------------------------------------------------
// sprite_rom
// Combinational 8x8 bitmaps for the player ship and the enemy ship.
//   sel      in  1  0 = player ship, 1 = enemy ship
//   row      in  3  sprite row (0 = top)
//   col      in  3  sprite column (0 = left)
//   pixel_on out 1  bitmap bit at (row, col)
//   colour   out 3  sprite colour when the bit is set, black otherwise
// -----------------------------------------------------------------------------
module sprite_rom
    import draw_pkg::*;
(
    input  logic       sel,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel_on,
    output logic [2:0] colour
);

    logic centre_col;
    logic full_row;

    always_comb begin
        centre_col = (col == 3'd3) || (col == 3'd4);
        // Ship: narrow nose on rows 0-3, solid body on rows 4-7.
        // Enemy is the same shape flipped top-to-bottom.
        full_row   = sel ? ~row[2] : row[2];
        pixel_on   = full_row | centre_col;
        if (pixel_on) begin
            colour = sel ? COL_RED : COL_GREEN;
        end else begin
            colour = COL_BLACK;
        end
    end

endmodule

// File: rtl/frame_draw_engine.sv
// -----------------------------------------------------------------------------
// frame_draw_engine
// Scans one drawing layer per start pulse and emits one registered pixel per
// cycle to the 160x120 VGA adapter.
//
// Build option: define SPRITE_TRANSPARENT_EN to suppress plot on clear sprite
// bitmap bits (background and bullet layers unaffected).
//
// Ports:
//   clk      in   1  system clock
//   reset    in   1  synchronous, active-high reset
//   start    in   1  single-cycle draw request (ignored unless idle)
//   layer    in   2  0=background, 1=ship, 2=enemy, 3=bullet
//   user_x   in   8  player ship left column
//   enemy_x  in   8  enemy ship left column
//   bullet_x in   8  bullet column
//   bullet_y in   7  bullet top row
//   vga_x    out  8  pixel column
//   vga_y    out  7  pixel row
//   colour   out  3  pixel colour
//   plot     out  1  write strobe (0 for off-screen pixels)
//   busy     out  1  high while scanning
//   done     out  1  one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module frame_draw_engine
    import draw_pkg::*;
#(
    parameter int         SCREEN_W  = SCREEN_W_DEF,
    parameter int         SCREEN_H  = SCREEN_H_DEF,
    parameter int         SHIP_Y    = 110,
    parameter int         ENEMY_Y   = 4,
    parameter logic [2:0] BG_COLOUR = 3'b000
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] layer,
    input  logic [7:0] user_x,
    input  logic [7:0] enemy_x,
    input  logic [7:0] bullet_x,
    input  logic [6:0] bullet_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    state_t     state_q;
    logic [1:0] layer_q;
    logic [7:0] ox_q;
    logic [6:0] oy_q;
    logic [7:0] w_q;
    logic [6:0] h_q;
    logic [7:0] col_q;
    logic [6:0] row_q;

    logic [7:0] vga_x_q;
    logic [6:0] vga_y_q;
    logic [2:0] colour_q;
    logic       plot_q;
    logic       busy_q;
    logic       done_q;

    // Geometry of the request presented on the inputs this cycle.
    logic [7:0] req_ox;
    logic [6:0] req_oy;
    logic [7:0] req_w;
    logic [6:0] req_h;

    // Counter advance within the latched scan.
    logic       col_wrap;
    logic       scan_last;
    logic [7:0] col_d;
    logic [6:0] row_d;

    // The pixel that will be shown after the next clock edge.
    logic [1:0] pix_layer;
    logic [7:0] pix_ox;
    logic [6:0] pix_oy;
    logic [7:0] pix_col;
    logic [6:0] pix_row;
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       on_screen;
    logic [2:0] pix_colour;
    logic       pix_plot;

    logic       rom_on;
    logic [2:0] rom_colour;

    always_comb begin
        req_ox = 8'd0;
        req_oy = 7'd0;
        req_w  = 8'(SCREEN_W);
        req_h  = 7'(SCREEN_H);
        case (layer)
            LAYER_SHIP: begin
                req_ox = user_x;
                req_oy = 7'(SHIP_Y);
                req_w  = SPRITE_W;
                req_h  = SPRITE_H;
            end
            LAYER_ENEMY: begin
                req_ox = enemy_x;
                req_oy = 7'(ENEMY_Y);
                req_w  = SPRITE_W;
                req_h  = SPRITE_H;
            end
            LAYER_BULLET: begin
                req_ox = bullet_x;
                req_oy = bullet_y;
                req_w  = BULLET_W;
                req_h  = BULLET_H;
            end
            default: begin
                req_ox = 8'd0;
                req_oy = 7'd0;
                req_w  = 8'(SCREEN_W);
                req_h  = 7'(SCREEN_H);
            end
        endcase
    end

    always_comb begin
        col_wrap  = (col_q == (w_q - 8'd1));
        scan_last = col_wrap && (row_q == (h_q - 7'd1));
        if (col_wrap) begin
            col_d = 8'd0;
            row_d = row_q + 7'd1;
        end else begin
            col_d = col_q + 8'd1;
            row_d = row_q;
        end
    end

    // In IDLE the first pixel is built straight from the request inputs so it
    // is on the outputs the cycle after start; during SCAN it comes from the
    // latched request and the advanced counters.
    always_comb begin
        if (state_q == ST_IDLE) begin
            pix_layer = layer;
            pix_ox    = req_ox;
            pix_oy    = req_oy;
            pix_col   = 8'd0;
            pix_row   = 7'd0;
        end else begin
            pix_layer = layer_q;
            pix_ox    = ox_q;
            pix_oy    = oy_q;
            pix_col   = col_d;
            pix_row   = row_d;
        end
    end

    sprite_rom u_sprite_rom (
        .sel      (pix_layer == LAYER_ENEMY),
        .row      (pix_row[2:0]),
        .col      (pix_col[2:0]),
        .pixel_on (rom_on),
        .colour   (rom_colour)
    );

    always_comb begin
        // Wide sums so sprites hanging off the right/bottom edge clip rather
        // than wrap back onto the screen.
        x_sum     = {1'b0, pix_ox} + {1'b0, pix_col};
        y_sum     = {1'b0, pix_oy} + {1'b0, pix_row};
        on_screen = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));

        case (pix_layer)
            LAYER_BG:     pix_colour = BG_COLOUR;
            LAYER_SHIP,
            LAYER_ENEMY:  pix_colour = rom_on ? rom_colour : COL_BLACK;
            default:      pix_colour = COL_YELLOW;
        endcase

`ifdef SPRITE_TRANSPARENT_EN
        pix_plot = on_screen && !(is_sprite(pix_layer) && !rom_on);
`else
        pix_plot = on_screen;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            layer_q  <= LAYER_BG;
            ox_q     <= 8'd0;
            oy_q     <= 7'd0;
            w_q      <= 8'd0;
            h_q      <= 7'd0;
            col_q    <= 8'd0;
            row_q    <= 7'd0;
            vga_x_q  <= 8'd0;
            vga_y_q  <= 7'd0;
            colour_q <= COL_BLACK;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    plot_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q  <= ST_SCAN;
                        layer_q  <= layer;
                        ox_q     <= req_ox;
                        oy_q     <= req_oy;
                        w_q      <= req_w;
                        h_q      <= req_h;
                        col_q    <= 8'd0;
                        row_q    <= 7'd0;
                        busy_q   <= 1'b1;
                        vga_x_q  <= x_sum[7:0];
                        vga_y_q  <= y_sum[6:0];
                        colour_q <= pix_colour;
                        plot_q   <= pix_plot;
                    end
                end
                ST_SCAN: begin
                    if (scan_last) begin
                        state_q <= ST_FINISH;
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        col_q    <= col_d;
                        row_q    <= row_d;
                        vga_x_q  <= x_sum[7:0];
                        vga_y_q  <= y_sum[6:0];
                        colour_q <= pix_colour;
                        plot_q   <= pix_plot;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vga_x  = vga_x_q;
    assign vga_y  = vga_y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_frame_draw_engine.sv
// -----------------------------------------------------------------------------
// tb_frame_draw_engine
// Self-checking bench: every scan is compared pixel by pixel against a
// reference model computed from the layer geometry and sprite shape rules.
// -----------------------------------------------------------------------------
module tb_frame_draw_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] layer;
    logic [7:0] user_x;
    logic [7:0] enemy_x;
    logic [7:0] bullet_x;
    logic [6:0] bullet_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    frame_draw_engine dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .layer    (layer),
        .user_x   (user_x),
        .enemy_x  (enemy_x),
        .bullet_x (bullet_x),
        .bullet_y (bullet_y),
        .vga_x    (vga_x),
        .vga_y    (vga_y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    // Sprite shape from its description: ship has a 2-pixel nose on the top
    // four rows and a full body underneath; the enemy is upside down.
    function automatic bit model_sprite_on(input int lay, input int r, input int c);
        bit centre;
        centre = (c == 3) || (c == 4);
        if (lay == 1) return centre || (r >= 4);
        return centre || (r < 4);
    endfunction

    // Runs one complete scan and compares every cycle against the model.
    // noise: scramble request inputs and fire stray starts during the scan.
    // restart_at: pixel index at which a second start pulse is presented.
    task automatic do_scan(input int lay, input int ux, input int ex, input int bx,
                           input int by, input bit noise, input int restart_at);
        int ox, oy, w, h, n;
        int r, c, x, y;
        bit exp_plot;
        logic [2:0] exp_col;
        logic [7:0] x8;
        logic [6:0] y7;
        case (lay)
            0: begin ox = 0;  oy = 0;   w = 160; h = 120; end
            1: begin ox = ux; oy = 110; w = 8;   h = 8;   end
            2: begin ox = ex; oy = 4;   w = 8;   h = 8;   end
            default: begin ox = bx; oy = by; w = 1; h = 2; end
        endcase
        n = w * h;

        @(negedge clk);
        layer    = 2'(lay);
        user_x   = 8'(ux);
        enemy_x  = 8'(ex);
        bullet_x = 8'(bx);
        bullet_y = 7'(by);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < n; i++) begin
            r = i / w;
            c = i % w;
            x = ox + c;
            y = oy + r;
            exp_plot = (x < 160) && (y < 120);
            case (lay)
                0: exp_col = 3'b000;
                1: exp_col = model_sprite_on(1, r, c) ? 3'b010 : 3'b000;
                2: exp_col = model_sprite_on(2, r, c) ? 3'b100 : 3'b000;
                default: exp_col = 3'b110;
            endcase
`ifdef SPRITE_TRANSPARENT_EN
            if ((lay == 1 || lay == 2) && !model_sprite_on(lay, r, c)) exp_plot = 1'b0;
`endif
            x8 = 8'(x);
            y7 = 7'(y);
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || plot !== exp_plot ||
                (exp_plot && (vga_x !== x8 || vga_y !== y7 || colour !== exp_col))) begin
                miscompares++;
                $display("FAIL scan_pixel layer=%0d idx=%0d: got busy=%b done=%b plot=%b x=%0d y=%0d col=%b, want busy=1 done=0 plot=%b x=%0d y=%0d col=%b",
                         lay, i, busy, done, plot, vga_x, vga_y, colour,
                         exp_plot, x8, y7, exp_col);
            end
            if (noise) begin
                layer    = 2'($urandom_range(0, 3));
                user_x   = 8'($urandom);
                enemy_x  = 8'($urandom);
                bullet_x = 8'($urandom);
                bullet_y = 7'($urandom);
                start    = 1'($urandom_range(0, 1));
            end else begin
                start = (i == restart_at);
            end
            @(negedge clk);
        end

        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0) begin
            miscompares++;
            $display("FAIL finish_cycle layer=%0d: got done=%b busy=%b plot=%b, want done=1 busy=0 plot=0",
                     lay, done, busy, plot);
        end
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin
            miscompares++;
            $display("FAIL after_finish layer=%0d: got done=%b busy=%b plot=%b, want all 0",
                     lay, done, busy, plot);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        layer = 2'd0;
        user_x = 8'd0;
        enemy_x = 8'd0;
        bullet_x = 8'd0;
        bullet_y = 7'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                vga_x !== 8'd0 || vga_y !== 7'd0 || colour !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_idle cycle=%0d: got plot=%b busy=%b done=%b x=%0d y=%0d col=%b, want all 0",
                         i, plot, busy, done, vga_x, vga_y, colour);
            end
        end
    endtask

    task automatic test_background();
        do_scan(0, 0, 0, 0, 0, 1'b0, -1);
    endtask

    task automatic test_ship();
        do_scan(1, 80, 0, 0, 0, 1'b0, -1);
    endtask

    task automatic test_enemy_clip();
        do_scan(2, 0, 156, 0, 0, 1'b0, -1);
    endtask

    task automatic test_bullet_double_start();
        do_scan(3, 0, 0, 20, 50, 1'b0, 0);
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        layer = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: got plot=%b busy=%b done=%b, want all 0",
                     plot, busy, done);
        end
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            vectors++;
            if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL post_abort_quiet cycle=%0d: got plot=%b busy=%b done=%b, want all 0",
                         i, plot, busy, done);
            end
        end
        do_scan(3, 0, 0, 20, 50, 1'b0, -1);
    endtask

    task automatic test_random();
        int lay;
        for (int k = 0; k < 12; k++) begin
            lay = $urandom_range(1, 3);
            do_scan(lay, $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 127), 1'b1, -1);
        end
        // Edge-hugging positions.
        do_scan(1, 152, 0, 0, 0, 1'b1, -1);
        do_scan(2, 0, 255, 0, 0, 1'b1, -1);
        do_scan(3, 0, 0, 159, 118, 1'b1, -1);
        do_scan(3, 0, 0, 159, 119, 1'b1, -1);
        do_scan(3, 0, 0, 160, 10, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_background();
        test_ship();
        test_enemy_clip();
        test_bullet_double_start();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
